// File: rtl/note_draw_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | note_draw_sequencer_pkg: FSM states, grid defaults and colours  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package note_draw_sequencer_pkg;

  localparam int COLS_DEF = 5;
  localparam int ROWS_DEF = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_LOAD,
    S_CLR_SCAN,
    S_CLR_WAIT,
    S_SHIFT,
    S_DRW_LOAD,
    S_DRW_SCAN,
    S_DRW_WAIT,
    S_DONE
  } state_t;

  // 3-bit RGB per note column, indexed by col_idx (1..5)
  localparam logic [2:0] COLOUR_GREEN  = 3'b010;
  localparam logic [2:0] COLOUR_RED    = 3'b100;
  localparam logic [2:0] COLOUR_YELLOW = 3'b110;
  localparam logic [2:0] COLOUR_BLUE   = 3'b001;
  localparam logic [2:0] COLOUR_ORANGE = 3'b101;

  function automatic logic [2:0] col_colour(input logic [2:0] idx);
    case (idx)
      3'd1:    col_colour = COLOUR_GREEN;
      3'd2:    col_colour = COLOUR_RED;
      3'd3:    col_colour = COLOUR_YELLOW;
      3'd4:    col_colour = COLOUR_BLUE;
      3'd5:    col_colour = COLOUR_ORANGE;
      default: col_colour = 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_draw_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | note_draw_sequencer_if: beat, note-register and plotter signals |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
interface note_draw_sequencer_if #(
  parameter int COLS = 5
) ();
  logic            i_beat;
  logic            i_pause;
  logic            i_stop;
  logic [COLS-1:0] i_row_data;
  logic            i_plot_ack;
  logic [2:0]      o_row_addr;
  logic [2:0]      o_col_idx;
  logic [8:0]      o_x_out;
  logic [7:0]      o_y_out;
  logic            o_plot_req;
  logic            o_plot_erase;
  logic            o_shift_en;
  logic            o_busy;
  logic            o_frame_done;
  logic            o_overrun;

  modport slave (
    input  i_beat, i_pause, i_stop, i_row_data, i_plot_ack,
    output o_row_addr, o_col_idx, o_x_out, o_y_out, o_plot_req,
           o_plot_erase, o_shift_en, o_busy, o_frame_done, o_overrun
  );

  modport master (
    output i_beat, i_pause, i_stop, i_row_data, i_plot_ack,
    input  o_row_addr, o_col_idx, o_x_out, o_y_out, o_plot_req,
           o_plot_erase, o_shift_en, o_busy, o_frame_done, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/note_draw_sequencer_coord.sv
`default_nettype none
// +----------------------------------------------------------------+
// | note_cell_coord: grid row/column to cell top-left pixel         |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module note_cell_coord #(
  parameter logic [8:0] X_ORIGIN  = 9'd100,
  parameter logic [8:0] COL_PITCH = 9'd24,
  parameter logic [7:0] Y_ORIGIN  = 8'd16,
  parameter logic [7:0] ROW_PITCH = 8'd28
) (
  input  wire logic [2:0] i_row,
  input  wire logic [2:0] i_col,
  output logic      [8:0] o_x,
  output logic      [7:0] o_y
);
  // products deliberately wrap at output width
  assign o_x = X_ORIGIN + 9'(i_col) * COL_PITCH;
  assign o_y = Y_ORIGIN + 8'(i_row) * ROW_PITCH;
endmodule
`default_nettype wire

// File: rtl/note_draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | note_draw_sequencer: per-beat erase / shift / draw controller   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module note_draw_sequencer
  import note_draw_sequencer_pkg::*;
#(
  parameter int         COLS      = COLS_DEF,
  parameter int         ROWS      = ROWS_DEF,
  parameter logic [8:0] X_ORIGIN  = 9'd100,
  parameter logic [8:0] COL_PITCH = 9'd24,
  parameter logic [7:0] Y_ORIGIN  = 8'd16,
  parameter logic [7:0] ROW_PITCH = 8'd28
) (
  input wire logic             clk,
  input wire logic             resetn,
  note_draw_sequencer_if.slave bus
);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);
  localparam logic [2:0] COL_END  = 3'(COLS);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  state_t          r_state, w_next;
  logic [2:0]      r_row, w_row, r_col, w_col;
  logic [COLS-1:0] r_shadow, w_shadow;
  logic            r_pending, w_pending, r_abort, w_abort, r_overrun, w_overrun;
  logic [2:0]      r_col_idx, w_col_idx;
  logic [8:0]      r_x, w_x, w_cell_x;
  logic [7:0]      r_y, w_y, w_cell_y;
  logic            r_plot_req, w_plot_req, r_plot_erase, w_plot_erase;
  logic            r_shift_en, w_shift_en, r_busy, w_busy, r_frame_done, w_frame_done;
  logic            w_clr_phase, w_in_scan, w_in_wait, w_bit, w_beat_ok;
  logic [7:0]      w_shadow_ext;

  note_cell_coord #(
    .X_ORIGIN (X_ORIGIN),
    .COL_PITCH(COL_PITCH),
    .Y_ORIGIN (Y_ORIGIN),
    .ROW_PITCH(ROW_PITCH)
  ) u_coord (
    .i_row(r_row),
    .i_col(r_col),
    .o_x  (w_cell_x),
    .o_y  (w_cell_y)
  );

  always_comb begin
    w_next       = r_state;
    w_row        = r_row;
    w_col        = r_col;
    w_shadow     = r_shadow;
    w_pending    = r_pending;
    w_abort      = r_abort;
    w_overrun    = r_overrun;
    w_clr_phase  = (r_state == S_CLR_LOAD) || (r_state == S_CLR_SCAN) || (r_state == S_CLR_WAIT);
    w_in_scan    = (r_state == S_CLR_SCAN) || (r_state == S_DRW_SCAN);
    w_in_wait    = (r_state == S_CLR_WAIT) || (r_state == S_DRW_WAIT);
    // zero-extended so the one-past-last column index stays in range
    w_shadow_ext = 8'(r_shadow);
    w_bit        = w_shadow_ext[r_col];
    w_beat_ok    = bus.i_beat & ~bus.i_pause & ~bus.i_stop;

    if (r_state != S_IDLE && w_beat_ok) begin
      if (r_pending) w_overrun = 1'b1;
      else           w_pending = 1'b1;
    end
    if (bus.i_stop) w_pending = 1'b0;

    case (r_state)
      S_IDLE: begin
        if ((bus.i_beat | r_pending) & ~bus.i_pause & ~bus.i_stop) begin
          w_next    = S_CLR_LOAD;
          w_row     = '0;
          w_pending = 1'b0;
        end
      end
      S_CLR_LOAD, S_DRW_LOAD: begin
        w_shadow = bus.i_row_data;
        w_col    = '0;
        w_next   = w_clr_phase ? S_CLR_SCAN : S_DRW_SCAN;
      end
      S_CLR_SCAN, S_DRW_SCAN: begin
        if ((r_col == COL_END) || (r_col == LAST_COL && !w_bit)) begin
          if (r_row == LAST_ROW) begin
            w_next = w_clr_phase ? S_SHIFT : S_DONE;
          end else begin
            w_row  = r_row + 3'd1;
            w_next = w_clr_phase ? S_CLR_LOAD : S_DRW_LOAD;
          end
        end else if (w_bit) begin
          w_next = w_clr_phase ? S_CLR_WAIT : S_DRW_WAIT;
        end else begin
          w_col = r_col + 3'd1;
        end
      end
      S_CLR_WAIT, S_DRW_WAIT: begin
        // a stop seen during the wait is remembered until the ack arrives
        if (bus.i_stop) w_abort = 1'b1;
        if (bus.i_plot_ack) begin
          if (bus.i_stop || r_abort) begin
            w_next = S_IDLE;
          end else begin
            w_col  = r_col + 3'd1;
            w_next = w_clr_phase ? S_CLR_SCAN : S_DRW_SCAN;
          end
        end
      end
      S_SHIFT: begin
        w_row  = '0;
        w_next = S_DRW_LOAD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    if (bus.i_stop && r_state != S_IDLE && !w_in_wait) w_next = S_IDLE;
    if (w_next == S_IDLE) w_abort = 1'b0;

    w_plot_req   = (w_next == S_CLR_WAIT) || (w_next == S_DRW_WAIT);
    w_plot_erase = (w_next == S_CLR_WAIT);
    w_shift_en   = (w_next == S_SHIFT);
    w_frame_done = (w_next == S_DONE);
    w_busy       = (w_next != S_IDLE);

    w_x       = r_x;
    w_y       = r_y;
    w_col_idx = r_col_idx;
    if (w_in_scan && w_plot_req) begin
      w_x       = w_cell_x;
      w_y       = w_cell_y;
      w_col_idx = r_col + 3'd1;
    end else if (w_next == S_IDLE) begin
      w_col_idx = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_abort      <= 1'b0;
      r_overrun    <= 1'b0;
      r_col_idx    <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_plot_req   <= 1'b0;
      r_plot_erase <= 1'b0;
      r_shift_en   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_row        <= w_row;
      r_col        <= w_col;
      r_shadow     <= w_shadow;
      r_pending    <= w_pending;
      r_abort      <= w_abort;
      r_overrun    <= w_overrun;
      r_col_idx    <= w_col_idx;
      r_x          <= w_x;
      r_y          <= w_y;
      r_plot_req   <= w_plot_req;
      r_plot_erase <= w_plot_erase;
      r_shift_en   <= w_shift_en;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
    end
  end

  assign bus.o_row_addr   = r_row;
  assign bus.o_col_idx    = r_col_idx;
  assign bus.o_x_out      = r_x;
  assign bus.o_y_out      = r_y;
  assign bus.o_plot_req   = r_plot_req;
  assign bus.o_plot_erase = r_plot_erase;
  assign bus.o_shift_en   = r_shift_en;
  assign bus.o_busy       = r_busy;
  assign bus.o_frame_done = r_frame_done;
  assign bus.o_overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_note_draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_note_draw_sequencer: note register + plotter model, checks   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_note_draw_sequencer;
  localparam int ACK_DLY = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  note_draw_sequencer_if #(.COLS(5)) bus ();
  note_draw_sequencer dut (.clk(clk), .resetn(resetn), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // note register model: loaded by the test, shifts down on shift_en
  logic [4:0] mem [8];
  logic [4:0] load_img [8];
  logic       load_go = 1'b0;
  always @(posedge clk) begin
    if (load_go) begin
      for (int r = 0; r < 8; r++) mem[r] <= load_img[r];
    end else if (bus.o_shift_en) begin
      for (int r = 7; r > 0; r--) mem[r] <= mem[r-1];
      mem[0] <= 5'd0;
    end
  end
  assign bus.i_row_data = mem[bus.o_row_addr];

  // plotter model: ack ACK_DLY cycles after a request rises
  logic ack_en = 1'b1, ack_draw = 1'b1, acked = 1'b0, prev_req = 1'b0;
  int   wcnt = 0, drop_err = 0;
  always @(negedge clk) begin
    bus.i_plot_ack = 1'b0;
    if (!resetn) begin
      wcnt  = 0;
      acked = 1'b0;
    end else begin
      if (prev_req && !bus.o_plot_req && !acked) drop_err++;
      if (!bus.o_plot_req) begin
        wcnt  = 0;
        acked = 1'b0;
      end else if (!acked) begin
        wcnt++;
        if (ack_en && (bus.o_plot_erase || ack_draw) && wcnt >= ACK_DLY) begin
          bus.i_plot_ack = 1'b1;
          acked          = 1'b1;
        end
      end
    end
    prev_req = bus.o_plot_req;
  end

  // request / shift recorder
  int   clr_n = 0, drw_n = 0, shift_n = 0, shift_cyc = 0;
  int   clr_x [256], clr_y [256], clr_col [256], drw_x [256], drw_y [256];
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.o_plot_req && !mon_prev) begin
        if (bus.o_plot_erase) begin
          clr_x[clr_n % 256]   = int'(bus.o_x_out);
          clr_y[clr_n % 256]   = int'(bus.o_y_out);
          clr_col[clr_n % 256] = int'(bus.o_col_idx);
          clr_n++;
        end else begin
          drw_x[drw_n % 256] = int'(bus.o_x_out);
          drw_y[drw_n % 256] = int'(bus.o_y_out);
          drw_n++;
        end
      end
      if (bus.o_shift_en) begin
        shift_n++;
        shift_cyc = cyc;
      end
    end
    mon_prev = bus.o_plot_req;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic load_one(input int row, input logic [4:0] word);
    @(negedge clk);
    for (int r = 0; r < 8; r++) load_img[r] = (r == row) ? word : 5'd0;
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  // edge_no is the posedge that samples the beat
  task automatic pulse_beat(output int edge_no);
    @(negedge clk);
    bus.i_beat = 1'b1;
    edge_no    = cyc + 1;
    @(negedge clk);
    bus.i_beat = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus.o_frame_done) begin
        at = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    int         row;
    logic [4:0] word;
    int         n_clr, n_drw, x, col, y_clr, y_drw, shift_lat, done_lat;
  } vec_t;
  vec_t vec [5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, at, at2, cb, db, sb, bh, seen;
    bus.i_beat  = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_stop  = 1'b0;
    for (int r = 0; r < 8; r++) load_img[r] = 5'd0;

    vec[0] = '{0, 5'b00000, 0, 0,   0, 0,   0,   0, 48,  97};
    vec[1] = '{3, 5'b00001, 1, 1, 100, 1, 100, 128, 52, 105};
    vec[2] = '{0, 5'b10000, 1, 1, 196, 5,  16,  44, 53, 107};
    vec[3] = '{7, 5'b00100, 1, 0, 148, 3, 212,   0, 52, 101};
    vec[4] = '{2, 5'b00011, 2, 2, 100, 1,  72, 100, 56, 113};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_plot_req", int'(bus.o_plot_req), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_overrun", int'(bus.o_overrun), 0);
    chk("rst_pulses", int'({bus.o_shift_en, bus.o_frame_done}), 0);
    chk("rst_coord", int'({bus.o_x_out, bus.o_y_out, bus.o_col_idx, bus.o_row_addr}), 0);
    resetn = 1'b1;
    load_one(0, 5'd0);

    for (int i = 0; i < 5; i++) begin
      load_one(vec[i].row, vec[i].word);
      cb = clr_n;
      db = drw_n;
      sb = shift_n;
      pulse_beat(e);
      wait_done(300, at);
      chk($sformatf("v%0d_done_lat", i), (at < 0) ? -1 : at - e, vec[i].done_lat);
      chk($sformatf("v%0d_shift_cnt", i), shift_n - sb, 1);
      chk($sformatf("v%0d_shift_lat", i), shift_cyc - e, vec[i].shift_lat);
      chk($sformatf("v%0d_erase_reqs", i), clr_n - cb, vec[i].n_clr);
      chk($sformatf("v%0d_draw_reqs", i), drw_n - db, vec[i].n_drw);
      if (vec[i].n_clr > 0) begin
        chk($sformatf("v%0d_erase_x", i), clr_x[cb % 256], vec[i].x);
        chk($sformatf("v%0d_erase_y", i), clr_y[cb % 256], vec[i].y_clr);
        chk($sformatf("v%0d_erase_col", i), clr_col[cb % 256], vec[i].col);
      end
      if (vec[i].n_drw > 0) begin
        chk($sformatf("v%0d_draw_x", i), drw_x[db % 256], vec[i].x);
        chk($sformatf("v%0d_draw_y", i), drw_y[db % 256], vec[i].y_drw);
      end
      repeat (2) @(negedge clk);
    end

    // pending beat and overrun
    load_one(0, 5'd0);
    pulse_beat(e);
    repeat (60) @(negedge clk);
    pulse_beat(at2);
    chk("pend_first_no_overrun", int'(bus.o_overrun), 0);
    repeat (10) @(negedge clk);
    pulse_beat(at2);
    chk("pend_second_overrun", int'(bus.o_overrun), 1);
    wait_done(300, at);
    chk("pend_done_lat", (at < 0) ? -1 : at - e, 97);
    @(negedge clk);
    chk("pend_idle_gap_busy", int'(bus.o_busy), 0);
    @(negedge clk);
    chk("pend_restart_busy", int'(bus.o_busy), 1);
    chk("pend_restart_row", int'(bus.o_row_addr), 0);
    wait_done(300, at2);
    chk("pend_frame2_gap", (at2 < 0 || at < 0) ? -1 : at2 - at, 99);
    repeat (3) @(negedge clk);

    // pause blocks the idle exit and is not remembered
    bus.i_pause = 1'b1;
    pulse_beat(e);
    bh = 0;
    repeat (6) begin @(negedge clk); bh += int'(bus.o_busy); end
    chk("pause_busy", bh, 0);
    bus.i_pause = 1'b0;
    repeat (6) begin @(negedge clk); bh += int'(bus.o_busy); end
    chk("pause_release_busy", bh, 0);

    // stop while waiting on an erase ack
    load_one(0, 5'b00001);
    ack_en = 1'b0;
    sb = shift_n;
    pulse_beat(e);
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.o_plot_req) seen = 1;
    end
    chk("stop_req_seen", seen, 1);
    bus.i_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_stop = 1'b0;
    repeat (5) @(negedge clk);
    chk("stop_req_held", int'(bus.o_plot_req), 1);
    chk("stop_busy_held", int'(bus.o_busy), 1);
    ack_en = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (!bus.o_plot_req) seen = 1;
    end
    chk("stop_req_released", seen, 1);
    chk("stop_idle_busy", int'(bus.o_busy), 0);
    chk("stop_idle_col", int'(bus.o_col_idx), 0);
    repeat (60) @(negedge clk);
    chk("stop_no_shift", shift_n - sb, 0);

    // asynchronous reset while a draw request is outstanding
    load_one(3, 5'b00001);
    ack_draw = 1'b0;
    pulse_beat(e);
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.o_plot_req && !bus.o_plot_erase) seen = 1;
    end
    chk("rstw_draw_req_seen", seen, 1);
    chk("rstw_overrun_before", int'(bus.o_overrun), 1);
    #2 resetn = 1'b0;
    #1;
    chk("rstw_plot_req", int'(bus.o_plot_req), 0);
    chk("rstw_busy", int'(bus.o_busy), 0);
    chk("rstw_overrun", int'(bus.o_overrun), 0);
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    ack_draw = 1'b1;
    load_one(0, 5'b00010);
    cb = clr_n;
    pulse_beat(e);
    chk("rstw_restart_busy", int'(bus.o_busy), 1);
    chk("rstw_restart_row", int'(bus.o_row_addr), 0);
    wait_done(300, at);
    chk("rstw_done_lat", (at < 0) ? -1 : at - e, 105);
    chk("rstw_erase_x", clr_x[cb % 256], 124);
    chk("rstw_erase_y", clr_y[cb % 256], 16);
    chk("rstw_erase_col", clr_col[cb % 256], 2);
    chk("rstw_overrun_clear", int'(bus.o_overrun), 0);

    repeat (3) @(negedge clk);
    chk("no_dropped_req", drop_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
